// File: rtl/cordic_pkg.sv
// Shared definitions for the rotational CORDIC and its angle pre-normaliser.
// Contents:
//   DEFAULT_WORD_LENGTH  default X/Y/Z width (signed Q6.11)
//   PI, HALF_PI, TWO_PI  Q6.11 angle constants, truncated
//   state_t              pre-normaliser FSM states
//   sat_neg()            two's-complement negate that clamps -MIN to +MAX
package cordic_pkg;

  localparam int DEFAULT_WORD_LENGTH = 18;

  localparam int PI      = 6433;   // 0x01921
  localparam int HALF_PI = 3216;   // 0x00C90
  localparam int TWO_PI  = 12867;  // 0x03243

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WRAP = 2'd1,
    ST_FOLD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // The most negative value has no positive counterpart, so it maps to the
  // most positive value instead of wrapping back onto itself.
  function automatic logic signed [DEFAULT_WORD_LENGTH-1:0] sat_neg(
    input logic signed [DEFAULT_WORD_LENGTH-1:0] v
  );
    logic signed [DEFAULT_WORD_LENGTH-1:0] most_neg;
    logic signed [DEFAULT_WORD_LENGTH-1:0] most_pos;
    most_neg = {1'b1, {(DEFAULT_WORD_LENGTH-1){1'b0}}};
    most_pos = {1'b0, {(DEFAULT_WORD_LENGTH-1){1'b1}}};
    if (v == most_neg) return most_pos;
    return -v;
  endfunction

endpackage

// File: rtl/cordic_angle_prenorm.sv
// Angle pre-normaliser in front of the rotational CORDIC.
// Takes an arbitrary signed Q6.11 angle Zi with vector (Xi, Yi), wraps the
// angle into [-PI, PI] one 2*PI step per cycle, folds it into
// [-PI/2, PI/2] by +/-PI (negating X and Y when folding), then hands the
// triple to the CORDIC with a one-cycle Start and waits for Cordic_Done.
// Ports:
//   CLK, RST            clock (rising edge), async active-low reset
//   ENABLE              request strobe, honoured only while Ready=1
//   Xi, Yi, Zi          input vector and angle
//   Cordic_Done         completion from the downstream CORDIC
//   Xo, Yo, Zo          normalised vector/angle, held until the next request
//   Start               one-cycle pulse to the CORDIC ENABLE
//   Ready               high only while idle
module cordic_angle_prenorm
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  input  logic [WORD_LENGTH-1:0] Xi,
  input  logic [WORD_LENGTH-1:0] Yi,
  input  logic [WORD_LENGTH-1:0] Zi,
  input  logic                   Cordic_Done,
  output logic [WORD_LENGTH-1:0] Xo,
  output logic [WORD_LENGTH-1:0] Yo,
  output logic [WORD_LENGTH-1:0] Zo,
  output logic                   Start,
  output logic                   Ready
);

  localparam logic signed [WORD_LENGTH-1:0] PI_C      = WORD_LENGTH'(PI);
  localparam logic signed [WORD_LENGTH-1:0] NEG_PI_C  = -PI_C;
  localparam logic signed [WORD_LENGTH-1:0] HPI_C     = WORD_LENGTH'(HALF_PI);
  localparam logic signed [WORD_LENGTH-1:0] NEG_HPI_C = -HPI_C;
  localparam logic signed [WORD_LENGTH-1:0] TWO_PI_C  = WORD_LENGTH'(TWO_PI);

  state_t state_q, state_d;
  logic signed [WORD_LENGTH-1:0] x_q, x_d;
  logic signed [WORD_LENGTH-1:0] y_q, y_d;
  logic signed [WORD_LENGTH-1:0] z_q, z_d;
  logic signed [WORD_LENGTH-1:0] xo_q, xo_d;
  logic signed [WORD_LENGTH-1:0] yo_q, yo_d;
  logic signed [WORD_LENGTH-1:0] zo_q, zo_d;
  logic start_q, start_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          x_d     = Xi;
          y_d     = Yi;
          z_d     = Zi;
          state_d = ST_WRAP;
        end
      end
      ST_WRAP: begin
        // Each step moves Z toward zero, so the add/sub cannot overflow.
        if (z_q > PI_C) begin
          z_d = z_q - TWO_PI_C;
        end else if (z_q < NEG_PI_C) begin
          z_d = z_q + TWO_PI_C;
        end else begin
          state_d = ST_FOLD;
        end
      end
      ST_FOLD: begin
        // Exactly +/-HALF_PI stays put; the CORDIC converges there.
        if (z_q > HPI_C) begin
          zo_d = z_q - PI_C;
          xo_d = sat_neg(x_q);
          yo_d = sat_neg(y_q);
        end else if (z_q < NEG_HPI_C) begin
          zo_d = z_q + PI_C;
          xo_d = sat_neg(x_q);
          yo_d = sat_neg(y_q);
        end else begin
          zo_d = z_q;
          xo_d = x_q;
          yo_d = y_q;
        end
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (Cordic_Done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      start_q <= start_d;
    end
  end

  assign Xo    = xo_q;
  assign Yo    = yo_q;
  assign Zo    = zo_q;
  assign Start = start_q;
  assign Ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_cordic_angle_prenorm.sv
module tb_cordic_angle_prenorm;

  localparam int WL = 18;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ENABLE = 1'b0;
  logic [WL-1:0] Xi = '0, Yi = '0, Zi = '0;
  logic          Cordic_Done = 1'b0;
  logic [WL-1:0] Xo, Yo, Zo;
  logic          Start, Ready;

  int checks = 0;
  int errors = 0;

  cordic_angle_prenorm #(.WORD_LENGTH(WL)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .Xi(Xi), .Yi(Yi), .Zi(Zi), .Cordic_Done(Cordic_Done),
    .Xo(Xo), .Yo(Yo), .Zo(Zo), .Start(Start), .Ready(Ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WL-1:0] x, y, z;
    logic [WL-1:0] ex, ey, ez;
    int            lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: angle reduction by whole turns, then a half-turn fold.
  function automatic void model(input logic [WL-1:0] x, y, z,
                                output logic [WL-1:0] ex, ey, ez, output int lat);
    int zi, xi, yi, n;
    bit neg;
    zi = int'($signed(z));
    xi = int'($signed(x));
    yi = int'($signed(y));
    n = 0;
    if (zi > 6433)       n = (zi - 6433 + 12866) / 12867;
    else if (zi < -6433) n = (-6433 - zi + 12866) / 12867;
    if (zi > 0) zi = zi - n * 12867;
    else        zi = zi + n * 12867;
    neg = 1'b0;
    if (zi > 3216)       begin zi = zi - 6433; neg = 1'b1; end
    else if (zi < -3216) begin zi = zi + 6433; neg = 1'b1; end
    if (neg) begin
      xi = -xi; if (xi > 131071) xi = 131071;
      yi = -yi; if (yi > 131071) yi = 131071;
    end
    ex = WL'(xi); ey = WL'(yi); ez = WL'(zi);
    lat = n + 2;
  endfunction

  // Accept a request at the next edge; returns just after that edge.
  task automatic accept(input logic [WL-1:0] x, y, z);
    chk("ready_before_req", 32'(Ready), 32'd1);
    Xi = x; Yi = y; Zi = z; ENABLE = 1'b1;
    @(posedge CLK); #1;
    ENABLE = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [WL-1:0] x, y, z,
                         input logic [WL-1:0] ex, ey, ez, input int lat, input bit noise);
    int c;
    bit seen;
    accept(x, y, z);
    seen = 1'b0;
    c = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      if (noise) begin ENABLE = 1'b1; Zi = WL'($urandom); end
      @(posedge CLK); #1;
      c = i;
      chk({tag, "_ready_busy"}, 32'(Ready), 32'd0);
      if (Start) seen = 1'b1;
    end
    ENABLE = 1'b0;
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(c), 32'(lat));
    chk({tag, "_xo"}, 32'(Xo), 32'(ex));
    chk({tag, "_yo"}, 32'(Yo), 32'(ey));
    chk({tag, "_zo"}, 32'(Zo), 32'(ez));
    if (noise) begin ENABLE = 1'b1; Zi = 18'h00100; end
    @(posedge CLK); #1;
    chk({tag, "_start_pulse_1cyc"}, 32'(Start), 32'd0);
    chk({tag, "_zo_hold"}, 32'(Zo), 32'(ez));
    chk({tag, "_ready_wait"}, 32'(Ready), 32'd0);
    Cordic_Done = 1'b1;
    @(posedge CLK); #1;
    Cordic_Done = 1'b0;
    ENABLE = 1'b0;
    chk({tag, "_ready_after_done"}, 32'(Ready), 32'd1);
    if (noise) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge CLK); #1;
        chk({tag, "_no_start_idle"}, 32'(Start), 32'd0);
        chk({tag, "_ready_idle"}, 32'(Ready), 32'd1);
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_start"}, 32'(Start), 32'd0);
    chk({tag, "_ready"}, 32'(Ready), 32'd1);
    chk({tag, "_xo"}, 32'(Xo), 32'd0);
    chk({tag, "_yo"}, 32'(Yo), 32'd0);
    chk({tag, "_zo"}, 32'(Zo), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [WL-1:0] ex, ey, ez;
    int lat;
    bit started;

    vecs[0] = '{18'h00800, 18'h01000, 18'h00C90, 18'h00800, 18'h01000, 18'h00C90, 2};
    vecs[1] = '{18'h01133, 18'h00A66, 18'h01855, 18'h3EECD, 18'h3F59A, 18'h3FF34, 2};
    vecs[2] = '{18'h00400, 18'h3FC00, 18'h033DD, 18'h00400, 18'h3FC00, 18'h0019A, 3};
    vecs[3] = '{18'h00123, 18'h00456, 18'h3D980, 18'h00123, 18'h00456, 18'h00BC3, 3};
    vecs[4] = '{18'h20000, 18'h00800, 18'h01921, 18'h1FFFF, 18'h3F800, 18'h00000, 2};
    vecs[5] = '{18'h00800, 18'h00800, 18'h3F370, 18'h00800, 18'h00800, 18'h3F370, 2};

    #12;
    chk_reset_state("reset");
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    chk_reset_state("post_reset");

    for (int i = 0; i < 6; i++)
      run_req($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].z,
              vecs[i].ex, vecs[i].ey, vecs[i].ez, vecs[i].lat, 1'b0);

    // Ten wraps with ENABLE noise during WRAP/WAIT and alongside Done.
    run_req("wrap10", 18'h00800, 18'h00000, 18'h1FFFF,
            18'h00800, 18'h00000, 18'h00961, 12, 1'b1);

    // Reset in the middle of the wrap sequence.
    accept(18'h00800, 18'h00400, 18'h1FFFF);
    repeat (4) @(posedge CLK);
    #1 RST = 1'b0;
    #1 chk_reset_state("rst_wrap");
    @(negedge CLK); RST = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (Start) started = 1'b1;
    end
    chk("rst_wrap_no_start", 32'(started), 32'd0);
    chk_reset_state("rst_wrap_after");

    // Reset while waiting for the CORDIC.
    accept(18'h01133, 18'h00A66, 18'h01855);
    repeat (3) @(posedge CLK);
    #1 chk("rst_wait_in_wait", 32'(Ready), 32'd0);
    RST = 1'b0;
    #1 chk_reset_state("rst_wait");
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    chk_reset_state("rst_wait_after");
    run_req("after_rst", vecs[1].x, vecs[1].y, vecs[1].z,
            vecs[1].ex, vecs[1].ey, vecs[1].ez, vecs[1].lat, 1'b0);

    // Randomized requests against the reference.
    for (int i = 0; i < 30; i++) begin
      logic [WL-1:0] rx, ry, rz;
      rx = WL'($urandom);
      ry = WL'($urandom);
      rz = WL'($urandom);
      if (i % 5 == 0) rx = 18'h20000;
      if (i % 3 == 0) rz = WL'($urandom_range(0, 12866) - 6433);
      model(rx, ry, rz, ex, ey, ez, lat);
      run_req($sformatf("rnd%0d", i), rx, ry, rz, ex, ey, ez, lat, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
